uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte-stream UART transmitter, 8N1, fed by an upstream byte producer (counters, LED/status generators) through a valid/ready handshake.
- Contains a small FIFO and an internal baud divider, so producers never need a separate baud clock or busy polling.
- Drives the board tx pin directly. Whole block runs in the single system clock domain clk.

Parameters:
- CLKS_PER_BIT, 344, clk cycles per UART bit (3.3 MHz / 9600 baud); legal range >= 2.
- FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8 entries.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, synchronous, active-low.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept a byte; transfer occurs on a rising clk edge with in_valid && in_ready.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  high while FIFO is non-empty or a frame is in progress.
- fifo_count  output  FIFO_AW+1  bytes currently queued, excluding the byte being shifted.

Behaviour:
- Reset (resetn low at a rising edge):
  - tx=1, FSM=IDLE, FIFO emptied, fifo_count=0, bit and baud counters=0.
  - in_ready is combinationally forced to 0 while resetn is low; tx_busy=0 after reset.
- in_ready = resetn && (fifo_count != 2**FIFO_AW). No writes when full; no overflow is possible.
- FIFO:
  - Circular buffer, FIFO_AW-bit read/write pointers wrapping naturally.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pop happens only when the FSM loads a byte.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see below).
  - IDLE: tx=1. If fifo_count != 0, pop the head into the shift register, clear the baud counter and go to START. tx=0 is registered on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 expires, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On expiry:
    - If the FIFO is non-empty, pop and go directly to START with no idle gap.
    - Otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). Wraps to 0 at each bit boundary; reloaded to 0 on every frame start.
- Frame length is exactly 10*CLKS_PER_BIT cycles. Back-to-back frames have zero extra cycles between stop and the next start.
- Latency: a byte accepted at edge N with the FIFO empty and FSM in IDLE drives tx low after edge N+1.
- tx_busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: the frame is aborted and tx returns high on the reset edge. Queued bytes are discarded.
- in_data is sampled only at the transfer edge; changes while in_ready=0 are ignored.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length is 11*CLKS_PER_BIT.
- When undefined: no PARITY state and no parity logic; frame is 10*CLKS_PER_BIT, 8N1.

Test Plan:
- Single byte: CLKS_PER_BIT=4, push 0x55 → tx low one cycle after accept; line shows 0,1,0,1,0,1,0,1,0,1 each 4 cycles; tx_busy deasserts after 40 cycles.
- Burst: CLKS_PER_BIT=4, push 0xA5 then 0x3C on consecutive cycles → two frames with no idle gap, 80 cycles total; fifo_count reads 1 then 0.
- Full FIFO: hold in_valid with the FSM busy, push 9 bytes 0x00..0x08 → first byte pops, 8 queue; in_ready=0 at fifo_count=8; all 9 bytes emerge in order.
- Reset mid-frame: assert resetn low during bit 3 of 0xFF with 3 bytes queued → tx=1 next edge, fifo_count=0, tx_busy=0; no further frames.
- Simultaneous push/pop: fifo_count=2, push a byte on the same edge as the STOP→START pop → fifo_count stays 2.
- With UART_TX_PARITY_EN: send 0x07 → parity bit 1; send 0x03 → parity bit 0; frame length 44 cycles at CLKS_PER_BIT=4.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed through a small byte FIFO, with internal baud divider.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1 frame).
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 344,
    parameter int unsigned FIFO_AW      = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    output logic             tx_busy,
    output logic [FIFO_AW:0] fifo_count
);
    localparam int unsigned DEPTH  = 2 ** FIFO_AW;
    localparam int unsigned CNT_W  = FIFO_AW + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]         state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic               push;
    logic               pop;
    logic               baud_done;
    logic               fifo_nempty;
`ifdef UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign in_ready    = resetn && (count_q != CNT_FULL);
    assign push        = in_valid && in_ready;
    assign fifo_nempty = (count_q != '0);
    assign baud_done   = (baud_q == BAUD_LAST);

    assign tx         = tx_q;
    assign fifo_count = count_q;
    assign tx_busy    = (state_q != S_IDLE) || fifo_nempty;

    // Frame sequencing; pop happens only when a new frame is loaded
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more data is queued
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized scoreboard bench for uart_tx_fifo; expected line levels come
// from a queueing model (frame start = max(accept+1, previous start + frame length)).
module tb_uart_tx_fifo;
    localparam int CLKS  = 4;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FL = NBITS * CLKS;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_ready;
    logic        tx;
    logic        tx_busy;
    logic [AW:0] fifo_count;

    uart_tx_fifo #(.CLKS_PER_BIT(CLKS), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
    } ent_t;

    ent_t       sb[$];
    int         cyc         = 0;
    logic       rst_at_edge = 1'b1;
    bit         mon_en      = 1'b0;
    int         checks      = 0;
    int         errors      = 0;
    int         last_start  = -1000000;
    int         last_acc    = 0;
    int         cnt_exp;
    int         off;
    int         bidx;
    logic       line_exp;
    logic [7:0] rx;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PAR && idx == 9) return ^d;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= resetn;
    end

    // Monitor: compares every cycle against the model, decodes and checks whole frames
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_at_edge) begin
                sb.delete();
                chk("rst_tx", int'(tx), 1);
                chk("rst_count", int'(fifo_count), 0);
                chk("rst_busy", int'(tx_busy), 0);
                chk("rst_ready", int'(in_ready), int'(resetn));
            end else begin
                cnt_exp = 0;
                foreach (sb[i]) if (sb[i].start > cyc) cnt_exp++;
                line_exp = 1'b1;
                off      = -1;
                if (sb.size() != 0 && sb[0].start <= cyc) begin
                    off      = cyc - sb[0].start;
                    line_exp = frame_bit(sb[0].data, off / CLKS);
                end
                chk("line", int'(tx), int'(line_exp));
                chk("count", int'(fifo_count), cnt_exp);
                chk("busy", int'(tx_busy), int'(sb.size() != 0));
                chk("ready", int'(in_ready), int'(resetn && cnt_exp != DEPTH));
                if (off >= 0) begin
                    bidx = off / CLKS;
                    if (off % CLKS == CLKS / 2 && bidx >= 1 && bidx <= 8) rx[bidx-1] = tx;
                    if (off == FL - 1) begin
                        chk("frame_byte", int'(rx), int'(sb[0].data));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        #1 resetn = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        last_start = -1000000;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        #1 in_valid = 1'b0;
        in_data = 8'($urandom);
        repeat (n) @(posedge clk);
    endtask

    // Holds the byte valid until accepted; returns in the accepting edge's time slot
    task automatic push(input logic [7:0] b);
        bit rdy;
        int ncyc;
        int acc;
        int st;
        #1 in_valid = 1'b1;
        in_data = b;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            rdy  = in_ready;
            ncyc = cyc;
            @(posedge clk);
            if (rdy) begin
                acc = ncyc + 1;
                st  = (acc + 1 > last_start + FL) ? acc + 1 : last_start + FL;
                last_start = st;
                last_acc   = acc;
                sb.push_back('{b, st});
                return;
            end
        end
        chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int s0;
        @(posedge clk);
        do_reset();

        push(8'h55);
        idle(1);
        wait_idle(500);

        push(8'hA5);
        push(8'h3C);
        idle(1);
        wait_idle(500);

        for (int i = 0; i < 10; i++) push(8'(i));
        idle(1);
        wait_idle(3000);

        push(8'hFF);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        idle(18);
        do_reset();
        idle(120);

        // Push lands on the same edge as the stop-to-start pop
        push(8'h10);
        s0 = last_start;
        push(8'h11);
        push(8'h12);
        idle(s0 + FL - 1 - last_acc);
        push(8'h13);
        idle(1);
        wait_idle(1000);

        push(8'h07);
        idle(1);
        wait_idle(500);
        push(8'h03);
        idle(1);
        wait_idle(500);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 100));
            else if ($urandom_range(0, 1) == 1) idle(1);
            push(8'($urandom));
        end
        idle(1);
        wait_idle(8000);
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
